// File: rtl/pcs_rx_lock_ctrl_if.sv
// Signal bundle between the RX lock controller, the gearbox, pcs_sync_rx and the PMA.
interface pcs_rx_lock_ctrl_if #(
  parameter int unsigned HEAD_W = 2
);
  logic              sig_ok_i;
  logic              head_v_i;
  logic [HEAD_W-1:0] head_i;
  logic              sync_valid_o;
  logic [HEAD_W-1:0] sync_head_o;
  logic              sync_slip_i;
  logic              sync_lock_i;
  logic              gb_slip_o;
  logic              gb_slip_ack_i;
  logic              hi_ber_o;
  logic              link_up_o;
  logic [7:0]        slip_cnt_o;

  // Environment side: PMA, gearbox and pcs_sync_rx.
  modport master (
    output sig_ok_i, head_v_i, head_i, sync_slip_i, sync_lock_i, gb_slip_ack_i,
    input  sync_valid_o, sync_head_o, gb_slip_o, hi_ber_o, link_up_o, slip_cnt_o
  );

  // Controller side.
  modport slave (
    input  sig_ok_i, head_v_i, head_i, sync_slip_i, sync_lock_i, gb_slip_ack_i,
    output sync_valid_o, sync_head_o, gb_slip_o, hi_ber_o, link_up_o, slip_cnt_o
  );
endinterface

// File: rtl/pcs_rx_lock_ctrl.sv
// RX block-lock sequencer: header forwarding, handshaked gearbox slip,
// post-slip settle blanking, hi_ber monitor and link status.
module pcs_rx_lock_ctrl #(
  parameter int unsigned HEAD_W     = 2,
  parameter int unsigned SETTLE_CNT = 4,
  parameter int unsigned ACK_TO     = 16,
  parameter int unsigned BER_WIN    = 19531,
  parameter int unsigned BER_TH     = 16
) (
  input  logic                clk,
  input  logic                reset,
  pcs_rx_lock_ctrl_if.slave   bus
);

  localparam int unsigned SET_W = $clog2(SETTLE_CNT) + 1;
  localparam int unsigned TO_W  = $clog2(ACK_TO) + 1;
  localparam int unsigned WIN_W = $clog2(BER_WIN) + 1;
  localparam int unsigned ERR_W = $clog2(BER_TH) + 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SLIP   = 2'd2,
    SETTLE = 2'd3
  } state_e;

  state_e             state_q,    state_d;
  logic               gb_slip_q,  gb_slip_d;
  logic [CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic [SET_W-1:0]   settle_q,   settle_d;
  logic [TO_W-1:0]    to_q,       to_d;
  logic [WIN_W-1:0]   win_q,      win_d;
  logic [ERR_W-1:0]   err_q,      err_d;
  logic               hi_ber_q,   hi_ber_d;
  logic               link_up_q,  link_up_d;

  logic [HEAD_W-1:0]  head;
  logic               ber_active;
  logic               head_bad;
  logic [ERR_W-1:0]   err_sum;
  logic               ber_reached;
  logic               win_end;

  assign head = bus.head_i;

  // Headers pass straight through; valid only while running.
  assign bus.sync_head_o  = head;
  assign bus.sync_valid_o = bus.head_v_i & bus.sig_ok_i & (state_q == RUN);

  assign bus.gb_slip_o  = gb_slip_q;
  assign bus.slip_cnt_o = slip_cnt_q;
  assign bus.hi_ber_o   = hi_ber_q;
  assign bus.link_up_o  = link_up_q;

  // hi_ber bookkeeping terms for the current cycle.
  assign ber_active  = (state_q == RUN) && bus.sync_lock_i;
  assign head_bad    = bus.head_v_i && ((head == {HEAD_W{1'b0}}) || (head == {HEAD_W{1'b1}}));
  assign err_sum     = (head_bad && (err_q < ERR_W'(BER_TH))) ? err_q + ERR_W'(1) : err_q;
  assign ber_reached = (err_sum >= ERR_W'(BER_TH));
  assign win_end     = (win_q == WIN_W'(BER_WIN - 1));

  // Next-state, slip handshake, hi_ber monitor and link status.
  always_comb begin
    state_d    = state_q;
    gb_slip_d  = gb_slip_q;
    slip_cnt_d = slip_cnt_q;
    settle_d   = settle_q;
    to_d       = to_q;
    win_d      = win_q;
    err_d      = err_q;
    hi_ber_d   = hi_ber_q;
    link_up_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.sig_ok_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.sync_slip_i) begin
          state_d = SLIP;
          to_d    = '0;
        end
      end
      SLIP: begin
        if (!gb_slip_q) begin
          // Request rises one cycle after entering SLIP.
          gb_slip_d = 1'b1;
          to_d      = '0;
        end else if (bus.gb_slip_ack_i) begin
          gb_slip_d  = 1'b0;
          to_d       = '0;
          settle_d   = '0;
          slip_cnt_d = (slip_cnt_q == {CNT_W{1'b1}}) ? slip_cnt_q : slip_cnt_q + CNT_W'(1);
          state_d    = (SETTLE_CNT == 0) ? RUN : SETTLE;
        end else if (to_q == TO_W'(ACK_TO - 1)) begin
          // Gearbox never answered: abandon the slip and restart.
          gb_slip_d = 1'b0;
          to_d      = '0;
          state_d   = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      SETTLE: begin
        if (bus.head_v_i) begin
          if (settle_q == SET_W'(SETTLE_CNT - 1)) begin
            settle_d = '0;
            state_d  = RUN;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Error-rate window only runs while locked in RUN.
    if (!ber_active) begin
      win_d    = '0;
      err_d    = '0;
      hi_ber_d = 1'b0;
    end else if (win_end) begin
      win_d    = '0;
      err_d    = '0;
      hi_ber_d = ber_reached;
    end else begin
      win_d    = win_q + WIN_W'(1);
      err_d    = err_sum;
      hi_ber_d = hi_ber_q | ber_reached;
    end

    link_up_d = bus.sync_lock_i & ~hi_ber_d & (state_q == RUN);

    // Loss of signal overrides everything, including a same-cycle ack.
    if (!bus.sig_ok_i) begin
      state_d    = IDLE;
      gb_slip_d  = 1'b0;
      slip_cnt_d = '0;
      settle_d   = '0;
      to_d       = '0;
      win_d      = '0;
      err_d      = '0;
      hi_ber_d   = 1'b0;
      link_up_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gb_slip_q  <= 1'b0;
      slip_cnt_q <= '0;
      settle_q   <= '0;
      to_q       <= '0;
      win_q      <= '0;
      err_q      <= '0;
      hi_ber_q   <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gb_slip_q  <= gb_slip_d;
      slip_cnt_q <= slip_cnt_d;
      settle_q   <= settle_d;
      to_q       <= to_d;
      win_q      <= win_d;
      err_q      <= err_d;
      hi_ber_q   <= hi_ber_d;
      link_up_q  <= link_up_d;
    end
  end

endmodule

// File: tb/tb_pcs_rx_lock_ctrl.sv
// Bench for pcs_rx_lock_ctrl: cycle checker against a behavioural model plus directed scenarios.
module tb_pcs_rx_lock_ctrl;

  localparam int unsigned SETTLE_CNT = 4;
  localparam int unsigned ACK_TO     = 16;
  localparam int unsigned BER_WIN    = 19531;
  localparam int unsigned BER_TH     = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcs_rx_lock_ctrl_if #(.HEAD_W(2)) bus ();

  pcs_rx_lock_ctrl #(
    .HEAD_W(2), .SETTLE_CNT(SETTLE_CNT), .ACK_TO(ACK_TO),
    .BER_WIN(BER_WIN), .BER_TH(BER_TH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic hdr_ph = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: link is "running" unless idle, mid-slip or still blanking.
  bit m_idle     = 1'b1;
  int m_slip_t   = -1;   // -1 none, 0 requested, k>=1 request seen high for k cycles
  int m_settle   = 0;    // valid headers still to blank
  int m_slips    = 0;
  int m_pos      = 0;    // position within the BER window
  int m_err      = 0;
  bit m_hi       = 1'b0;
  bit m_link     = 1'b0;
  bit m_running;
  assign m_running = !m_idle && (m_slip_t < 0) && (m_settle == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idle <= 1'b1; m_slip_t <= -1; m_settle <= 0; m_slips <= 0;
      m_pos <= 0; m_err <= 0; m_hi <= 1'b0; m_link <= 1'b0;
    end else if (!bus.sig_ok_i) begin
      m_idle <= 1'b1; m_slip_t <= -1; m_settle <= 0; m_slips <= 0;
      m_pos <= 0; m_err <= 0; m_hi <= 1'b0; m_link <= 1'b0;
    end else begin : model_step
      bit hi_n, idle_n, reached;
      int slip_n, set_n, slips_n, pos_n, err_n;
      idle_n = m_idle; slip_n = m_slip_t; set_n = m_settle; slips_n = m_slips;
      if (m_running && bus.sync_lock_i) begin
        err_n = m_err;
        if (bus.head_v_i && (bus.head_i == 2'b00 || bus.head_i == 2'b11) && err_n < int'(BER_TH))
          err_n = err_n + 1;
        reached = (err_n >= int'(BER_TH));
        if (m_pos == int'(BER_WIN) - 1) begin
          hi_n = reached; pos_n = 0; err_n = 0;
        end else begin
          hi_n = m_hi || reached; pos_n = m_pos + 1;
        end
      end else begin
        hi_n = 1'b0; pos_n = 0; err_n = 0;
      end
      if (m_idle) idle_n = 1'b0;
      else if (m_running) begin
        if (bus.sync_slip_i) slip_n = 0;
      end else if (m_slip_t == 0) slip_n = 1;
      else if (m_slip_t >= 1) begin
        if (bus.gb_slip_ack_i) begin
          slips_n = (m_slips < 255) ? m_slips + 1 : 255;
          slip_n = -1;
          set_n = int'(SETTLE_CNT);
        end else if (m_slip_t == int'(ACK_TO)) begin
          slip_n = -1; idle_n = 1'b1;
        end else slip_n = m_slip_t + 1;
      end else if (bus.head_v_i) set_n = m_settle - 1;
      m_link   <= bus.sync_lock_i && !hi_n && m_running;
      m_hi     <= hi_n;
      m_pos    <= pos_n;
      m_err    <= err_n;
      m_idle   <= idle_n;
      m_slip_t <= slip_n;
      m_settle <= set_n;
      m_slips  <= slips_n;
    end
  end

  // Cycle checker on the falling edge.
  always @(negedge clk) begin
    chk("m_sync_valid", 32'(bus.sync_valid_o), 32'(bus.head_v_i & bus.sig_ok_i & m_running));
    chk("m_sync_head",  32'(bus.sync_head_o),  32'(bus.head_i));
    chk("m_gb_slip",    32'(bus.gb_slip_o),    32'(m_slip_t >= 1));
    chk("m_hi_ber",     32'(bus.hi_ber_o),     32'(m_hi));
    chk("m_link_up",    32'(bus.link_up_o),    32'(m_link));
    chk("m_slip_cnt",   32'(bus.slip_cnt_o),   32'(m_slips));
  end

  // Advance one clock; headers alternate 01/10 by default.
  task automatic cyc();
    @(posedge clk);
    #1;
    hdr_ph = ~hdr_ph;
    bus.head_i = hdr_ph ? 2'b10 : 2'b01;
  endtask

  // Pulse a slip request, then count request-high cycles; ack on the ack_at-th (0 = never).
  task automatic do_slip(input int ack_at, output int hi_cnt);
    int g;
    bus.sync_slip_i = 1'b1;
    cyc();
    bus.sync_slip_i = 1'b0;
    g = 0;
    while (!bus.gb_slip_o && g < 4) begin cyc(); g++; end
    if (!bus.gb_slip_o) chk("slip_rise_timeout", 32'(bus.gb_slip_o), 32'd1);
    hi_cnt = 0;
    g = 0;
    while (bus.gb_slip_o && g < 40) begin
      hi_cnt++;
      if (hi_cnt == ack_at) bus.gb_slip_ack_i = 1'b1;
      cyc();
      bus.gb_slip_ack_i = 1'b0;
      g++;
    end
  endtask

  // Count blanked valid header cycles until forwarding resumes.
  task automatic wait_run(output int nb);
    int g;
    nb = 0;
    g = 0;
    while (!bus.sync_valid_o && g < 20) begin nb++; cyc(); g++; end
  endtask

  initial begin
    int nv, hc, nb;
    reset = 1'b1;
    bus.sig_ok_i = 1'b0; bus.head_v_i = 1'b0; bus.head_i = 2'b01;
    bus.sync_slip_i = 1'b0; bus.sync_lock_i = 1'b0; bus.gb_slip_ack_i = 1'b0;
    repeat (3) cyc();
    chk("rst_gb_slip",  32'(bus.gb_slip_o),    32'd0);
    chk("rst_hi_ber",   32'(bus.hi_ber_o),     32'd0);
    chk("rst_link_up",  32'(bus.link_up_o),    32'd0);
    chk("rst_slip_cnt", 32'(bus.slip_cnt_o),   32'd0);
    reset = 1'b0;

    // Bring-up with lock arriving at cycle 64.
    bus.sig_ok_i = 1'b1; bus.head_v_i = 1'b1;
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 64) bus.sync_lock_i = 1'b1;
      #1;
      if (i >= 1) nv += int'(bus.sync_valid_o);
      if (i == 64) chk("t1_link_before_lock", 32'(bus.link_up_o), 32'd0);
      if (i == 65) chk("t1_link_after_lock",  32'(bus.link_up_o), 32'd1);
      cyc();
    end
    chk("t1_valid_count", 32'(nv), 32'd99);
    chk("t1_hi_ber",      32'(bus.hi_ber_o),   32'd0);
    chk("t1_slip_cnt",    32'(bus.slip_cnt_o), 32'd0);

    // Acked slip with settle blanking.
    do_slip(3, hc);
    chk("t2_slip_high_cycles", 32'(hc), 32'd3);
    wait_run(nb);
    chk("t2_blanked_headers", 32'(nb), 32'd4);
    chk("t2_slip_cnt",        32'(bus.slip_cnt_o), 32'd1);

    // Unacked slip times out back to IDLE.
    bus.sig_ok_i = 1'b0; cyc(); bus.sig_ok_i = 1'b1; cyc();
    chk("t3_cnt_cleared", 32'(bus.slip_cnt_o), 32'd0);
    do_slip(0, hc);
    chk("t3_slip_high_cycles", 32'(hc), 32'd16);
    chk("t3_idle_no_valid",    32'(bus.sync_valid_o), 32'd0);
    chk("t3_slip_cnt",         32'(bus.slip_cnt_o),   32'd0);
    cyc();
    chk("t3_run_again", 32'(bus.sync_valid_o), 32'd1);
    repeat (2) cyc();

    // hi_ber: 16 errors in window 1, 3 errors in window 2 (one on its last cycle).
    bus.sync_lock_i = 1'b0; cyc(); bus.sync_lock_i = 1'b1;
    for (int w = 0; w < 2 * int'(BER_WIN); w++) begin
      if ((w >= 10 && w <= 25) || w == int'(BER_WIN) + 100 ||
          w == int'(BER_WIN) + 200 || w == 2 * int'(BER_WIN) - 1)
        bus.head_i = 2'b11;
      #1;
      if (w == 25) chk("t4_hi_before_16th", 32'(bus.hi_ber_o), 32'd0);
      if (w == 26) begin
        chk("t4_hi_after_16th",   32'(bus.hi_ber_o),  32'd1);
        chk("t4_link_down",       32'(bus.link_up_o), 32'd0);
      end
      if (w == int'(BER_WIN))         chk("t4_hi_held_win1_end", 32'(bus.hi_ber_o), 32'd1);
      if (w == 2 * int'(BER_WIN) - 1) chk("t4_hi_before_win2_end", 32'(bus.hi_ber_o), 32'd1);
      cyc();
    end
    chk("t4_hi_cleared", 32'(bus.hi_ber_o),  32'd0);
    chk("t4_link_up",    32'(bus.link_up_o), 32'd1);

    // Saturating slip counter.
    for (int s = 0; s < 300; s++) begin
      do_slip(1, hc);
      wait_run(nb);
      if (s == 199) chk("t6_slip_cnt_200", 32'(bus.slip_cnt_o), 32'd200);
    end
    chk("t6_slip_cnt_sat", 32'(bus.slip_cnt_o), 32'd255);

    // Signal loss with ack on the same cycle.
    bus.sync_slip_i = 1'b1; cyc(); bus.sync_slip_i = 1'b0; cyc();
    chk("t5_gb_slip_high", 32'(bus.gb_slip_o), 32'd1);
    bus.sig_ok_i = 1'b0; bus.gb_slip_ack_i = 1'b1;
    cyc();
    bus.gb_slip_ack_i = 1'b0;
    chk("t5_gb_slip",  32'(bus.gb_slip_o),  32'd0);
    chk("t5_slip_cnt", 32'(bus.slip_cnt_o), 32'd0);
    chk("t5_link_up",  32'(bus.link_up_o),  32'd0);
    bus.sig_ok_i = 1'b1; cyc(); cyc();
    chk("t5_run_after", 32'(bus.sync_valid_o), 32'd1);
    repeat (2) cyc();

    // Async reset mid-slip and mid-settle.
    bus.sync_slip_i = 1'b1; cyc(); bus.sync_slip_i = 1'b0; cyc();
    chk("t7_gb_slip_high", 32'(bus.gb_slip_o), 32'd1);
    #1 reset = 1'b1;
    #1 chk("t7_gb_slip_async", 32'(bus.gb_slip_o), 32'd0);
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    do_slip(1, hc);
    chk("t7_settle_cnt", 32'(bus.slip_cnt_o), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t7_rst_slip_cnt", 32'(bus.slip_cnt_o),   32'd0);
    chk("t7_rst_gb_slip",  32'(bus.gb_slip_o),    32'd0);
    chk("t7_rst_hi_ber",   32'(bus.hi_ber_o),     32'd0);
    chk("t7_rst_link_up",  32'(bus.link_up_o),    32'd0);
    chk("t7_rst_valid",    32'(bus.sync_valid_o), 32'd0);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
